// File: rtl/apb_ratio_delayer.sv
// ----------------------------------------------------------------------------
// apb_ratio_delayer
//
// APB response delayer between the crossbar and a slow-peripheral model.
// Each transfer's device latency is measured in clock cycles (setup cycle
// included). The upstream transfer is then stretched to
// (latency * RATIO) >> FRAC_W cycles, which emulates a core clock that runs
// RATIO / 2^FRAC_W times faster than the device clock. The upstream transfer
// is never shorter than latency + 1 cycles, because the captured response is
// always replayed in its own RESP cycle.
//
// While the response is held back (HOLD) or replayed (RESP), psel/penable
// toward the device are forced low. The device therefore never sees a
// second access.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width (strobe width is DATA_W/8)
//   FRAC_W  fractional bits of RATIO
//   RATIO   unsigned fixed-point ratio with FRAC_W fractional bits
//           (48 with FRAC_W=4 is 3.0). Must be >= 1 << FRAC_W.
//   CNT_W   width of the latency and wait counters. Both saturate at
//           2^CNT_W-1 and never wrap.
//
// Ports:
//   clock                 sole clock, rising edge
//   reset                 asynchronous reset, active low
//   dly_bypass            (APB_RATIO_DELAYER_BYPASS_EN only) when high in
//                         IDLE, the device response passes straight through
//   in_paddr..in_pstrb    upstream APB request from the crossbar
//   in_pready/prdata/     delayed response to the crossbar
//   in_pslverr
//   out_paddr/pprot/      combinational copies of the upstream request
//   pwrite/pwdata/pstrb
//   out_psel/out_penable  upstream select/enable, gated by the FSM state
//   out_pready/prdata/    response from the device
//   out_pslverr
//
// Optional feature: define APB_RATIO_DELAYER_BYPASS_EN to add the dly_bypass
// input. When the macro is undefined, the delay is always applied.
// ----------------------------------------------------------------------------
module apb_ratio_delayer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 4,
    parameter int RATIO  = 48,
    parameter int CNT_W  = 12
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef APB_RATIO_DELAYER_BYPASS_EN
    input  logic                  dly_bypass,
`endif
    // upstream (crossbar) side
    input  logic [ADDR_W-1:0]     in_paddr,
    input  logic                  in_psel,
    input  logic                  in_penable,
    input  logic [2:0]            in_pprot,
    input  logic                  in_pwrite,
    input  logic [DATA_W-1:0]     in_pwdata,
    input  logic [DATA_W/8-1:0]   in_pstrb,
    output logic                  in_pready,
    output logic [DATA_W-1:0]     in_prdata,
    output logic                  in_pslverr,
    // downstream (device) side
    output logic [ADDR_W-1:0]     out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [DATA_W-1:0]     out_pwdata,
    output logic [DATA_W/8-1:0]   out_pstrb,
    input  logic                  out_pready,
    input  logic [DATA_W-1:0]     out_prdata,
    input  logic                  out_pslverr
);

    // ------------------------------------------------------------------------
    // Arithmetic sizing. The ratio operand is at least CNT_W bits wide and
    // wide enough to hold RATIO itself. This keeps the full product of
    // latency * RATIO before the fixed-point shift, even when RATIO does not
    // fit in CNT_W bits.
    // ------------------------------------------------------------------------
    localparam int RATIO_BITS = $clog2(RATIO + 1);
    localparam int RATIO_W    = (RATIO_BITS > CNT_W) ? RATIO_BITS : CNT_W;
    localparam int PROD_W     = CNT_W + RATIO_W;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PROD_W-1:0] RATIO_P  = PROD_W'(RATIO);
    localparam logic [PROD_W-1:0] CNT_MAXP = PROD_W'(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for a setup cycle
        ACCESS = 2'd1,  // device owns the transfer, latency being measured
        HOLD   = 2'd2,  // response captured, stretching the transfer
        RESP   = 2'd3   // single-cycle replay of the captured response
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    lat_cnt, lat_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_nxt;
    logic [DATA_W-1:0]   rdata_buf;
    logic                err_buf;
    logic                capture;

    logic                bypass_active;

`ifdef APB_RATIO_DELAYER_BYPASS_EN
    // dly_bypass takes effect only in IDLE. A change in the middle of a
    // transfer waits until the FSM is back in IDLE.
    assign bypass_active = dly_bypass && (state == IDLE);
`else
    assign bypass_active = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Latency and wait computation for the capture cycle.
    // lat_inc is the latency including the current cycle, saturated so that
    // a very slow device cannot wrap the count.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  lat_inc;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] total;
    logic [PROD_W-1:0] lat_plus1;
    logic [PROD_W-1:0] wait_full;
    logic [CNT_W-1:0]  wait_sat;

    assign lat_inc   = (lat_cnt == CNT_MAX) ? lat_cnt : lat_cnt + CNT_ONE;
    assign product   = PROD_W'(lat_inc) * RATIO_P;
    assign total     = product >> FRAC_W;
    assign lat_plus1 = PROD_W'(lat_inc) + PROD_W'(1);

    // The capture cycle and the RESP cycle already account for lat + 1
    // cycles. Any remainder of 'total' is spent in HOLD. A ratio near 1.0
    // can make the remainder negative, so it is floored at zero.
    assign wait_full = (total > lat_plus1) ? (total - lat_plus1) : '0;
    assign wait_sat  = (wait_full > CNT_MAXP) ? CNT_MAX : wait_full[CNT_W-1:0];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the values of the previous cycle,
    // regardless of the order of the statements.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Response buffer. It is loaded only in the capture cycle and keeps its
    // contents across an abort.
    // ------------------------------------------------------------------------
    // NOTE: the response buffer is an ordinary register, not a memory. It is
    // cleared on reset so that a replay can never expose stale data from
    // before reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_buf <= '0;
            err_buf   <= 1'b0;
        end else if (capture) begin
            rdata_buf <= out_prdata;
            err_buf   <= out_pslverr;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. A path that
    // forgets an assignment then keeps the default, and no latch is
    // inferred.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        wait_nxt  = wait_cnt;
        capture   = 1'b0;

        unique case (state)
            IDLE: begin
                // A setup cycle, or an access that skipped setup, starts
                // the measurement. The cycle in progress counts as
                // latency 1.
                if (in_psel && !bypass_active) begin
                    lat_nxt   = CNT_ONE;
                    state_nxt = ACCESS;
                end
            end

            ACCESS: begin
                if (!in_psel) begin
                    state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_inc;
                    if (out_pready && in_penable) begin
                        capture = 1'b1;
                        if (wait_sat == '0) begin
                            state_nxt = RESP;
                        end else begin
                            wait_nxt  = wait_sat;
                            state_nxt = HOLD;
                        end
                    end
                end
            end

            HOLD: begin
                if (!in_psel) begin
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt - CNT_ONE;
                    if (wait_cnt == CNT_ONE) begin
                        state_nxt = RESP;
                    end
                end
            end

            RESP: begin
                // Exactly one cycle. If the crossbar starts a new setup
                // right after the response, IDLE picks it up in the next
                // cycle.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Downstream request: copies of the upstream request, except select and
    // enable. Those are blocked in HOLD/RESP and while reset is low.
    // ------------------------------------------------------------------------
    logic dev_gate;

    assign dev_gate    = reset && ((state == IDLE) || (state == ACCESS));

    assign out_paddr   = in_paddr;
    assign out_pprot   = in_pprot;
    assign out_pwrite  = in_pwrite;
    assign out_pwdata  = in_pwdata;
    assign out_pstrb   = in_pstrb;
    assign out_psel    = in_psel    && dev_gate;
    assign out_penable = in_penable && dev_gate;

    // ------------------------------------------------------------------------
    // Upstream response: the buffer is replayed only in RESP. All response
    // outputs are zero otherwise, unless bypass passes the device straight
    // through while the FSM is IDLE.
    // ------------------------------------------------------------------------
    logic resp_cycle;
    logic pass_through;

    assign resp_cycle   = reset && (state == RESP);
    assign pass_through = reset && bypass_active;

    always_comb begin
        in_pready  = 1'b0;
        in_prdata  = '0;
        in_pslverr = 1'b0;
        if (pass_through) begin
            in_pready  = out_pready;
            in_prdata  = out_prdata;
            in_pslverr = out_pslverr;
        end else if (resp_cycle) begin
            in_pready  = 1'b1;
            in_prdata  = rdata_buf;
            in_pslverr = err_buf;
        end
    end

endmodule

// File: tb/tb_apb_ratio_delayer.sv
// ----------------------------------------------------------------------------
// tb_apb_ratio_delayer
//
// Directed bench for apb_ratio_delayer. Three instances share the upstream
// request and the device response:
//   u_main  : RATIO=48 (3.0), CNT_W=12
//   u_unity : RATIO=16 (1.0), CNT_W=12
//   u_sat   : RATIO=48 (3.0), CNT_W=4 (counter saturation)
// Only one instance is observed in each test. Inputs are driven 1 ns after
// the rising edge. Outputs are sampled on the falling edge. Cycle 1 is the
// setup cycle.
// ----------------------------------------------------------------------------
module tb_apb_ratio_delayer;

    localparam int MAIN  = 0;
    localparam int UNITY = 1;
    localparam int SAT   = 2;

    logic        clock;
    logic        reset;

    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;

    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    logic        rdy     [3];
    logic [31:0] rdat    [3];
    logic        rerr    [3];
    logic [31:0] o_paddr [3];
    logic        o_psel  [3];
    logic        o_pen   [3];
    logic [2:0]  o_pprot [3];
    logic        o_pwrite[3];
    logic [31:0] o_pwdata[3];
    logic [3:0]  o_pstrb [3];

    int n_tests = 0;
    int n_fail  = 0;

    apb_ratio_delayer u_main (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb),
        .in_pready(rdy[0]), .in_prdata(rdat[0]), .in_pslverr(rerr[0]),
        .out_paddr(o_paddr[0]), .out_psel(o_psel[0]), .out_penable(o_pen[0]),
        .out_pprot(o_pprot[0]), .out_pwrite(o_pwrite[0]),
        .out_pwdata(o_pwdata[0]), .out_pstrb(o_pstrb[0]),
        .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    apb_ratio_delayer #(.RATIO(16)) u_unity (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb),
        .in_pready(rdy[1]), .in_prdata(rdat[1]), .in_pslverr(rerr[1]),
        .out_paddr(o_paddr[1]), .out_psel(o_psel[1]), .out_penable(o_pen[1]),
        .out_pprot(o_pprot[1]), .out_pwrite(o_pwrite[1]),
        .out_pwdata(o_pwdata[1]), .out_pstrb(o_pstrb[1]),
        .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    apb_ratio_delayer #(.CNT_W(4)) u_sat (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb),
        .in_pready(rdy[2]), .in_prdata(rdat[2]), .in_pslverr(rerr[2]),
        .out_paddr(o_paddr[2]), .out_psel(o_psel[2]), .out_penable(o_pen[2]),
        .out_pprot(o_pprot[2]), .out_pwrite(o_pwrite[2]),
        .out_pwdata(o_pwdata[2]), .out_pstrb(o_pstrb[2]),
        .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net: every loop is bounded, but never allow a hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        in_psel     = 1'b0;
        in_penable  = 1'b0;
        out_pready  = 1'b0;
        out_prdata  = '0;
        out_pslverr = 1'b0;
    endtask

    task automatic pulse_reset();
        drive_idle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
    endtask

    // One idle cycle on the bus. Returns the sampled response of one instance.
    task automatic idle_cycle(input int sel, output logic r, output logic e);
        drive_idle();
        @(negedge clock);
        r = rdy[sel];
        e = rerr[sel];
        next_cycle();
    endtask

    // A full transfer as seen by instance 'sel'. The device raises
    // out_pready from cycle dev_lat on. Returns the cycle in which in_pready
    // was seen (-1 if never), the returned data and error, and the number of
    // cycles in which the device saw out_psel. The task leaves the bus in
    // the access phase, so the caller can start a back-to-back setup.
    task automatic do_xfer(input int sel, input int dev_lat, input logic wr,
                           input logic [31:0] rdata, input logic err,
                           input int max_cyc, output int rc,
                           output logic [31:0] d, output logic e,
                           output int pc);
        logic hit;
        rc = -1;
        d  = '0;
        e  = 1'b0;
        pc = 0;
        in_pwrite = wr;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            in_psel     = 1'b1;
            in_penable  = (cyc > 1);
            out_pready  = (cyc >= dev_lat);
            out_prdata  = (cyc >= dev_lat) ? rdata : 32'h0;
            out_pslverr = (cyc >= dev_lat) ? err : 1'b0;
            @(negedge clock);
            pc += int'(o_psel[sel]);
            hit = rdy[sel];
            if (hit) begin
                rc = cyc;
                d  = rdat[sel];
                e  = rerr[sel];
            end
            next_cycle();
            if (hit) break;
        end
        out_pready  = 1'b0;
        out_prdata  = '0;
        out_pslverr = 1'b0;
    endtask

    initial begin
        int          rc;
        int          pc;
        int          seen;
        logic [31:0] d;
        logic        e;
        logic        r;

        reset       = 1'b0;
        in_paddr    = 32'h4000_1230;
        in_pprot    = 3'b010;
        in_pwrite   = 1'b0;
        in_pwdata   = 32'h5555_AAAA;
        in_pstrb    = 4'hF;
        drive_idle();

        // ---------------- reset state -----------------------------------
        next_cycle();
        in_psel    = 1'b1;
        in_penable = 1'b1;
        @(negedge clock);
        check("rst_pready",  {31'd0, rdy[MAIN]},   32'd0);
        check("rst_prdata",  rdat[MAIN],           32'd0);
        check("rst_pslverr", {31'd0, rerr[MAIN]},  32'd0);
        check("rst_out_psel", {31'd0, o_psel[MAIN]}, 32'd0);
        check("rst_out_pen",  {31'd0, o_pen[MAIN]},  32'd0);
        check("paddr_copy",  o_paddr[MAIN],        32'h4000_1230);
        check("pwdata_copy", o_pwdata[MAIN],       32'h5555_AAAA);
        next_cycle();
        drive_idle();
        reset = 1'b1;
        next_cycle();

        // ---------------- RATIO 3.0, lat=2 -> total 6 --------------------
        do_xfer(MAIN, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 20, rc, d, e, pc);
        check("r3_lat2_cycle", rc, 32'd6);
        check("r3_lat2_data",  d,  32'hDEAD_BEEF);
        check("r3_lat2_err",   {31'd0, e}, 32'd0);
        check("r3_lat2_psel",  pc, 32'd2);

        // Back-to-back: lat=3 -> total 9
        do_xfer(MAIN, 3, 1'b0, 32'h1234_5678, 1'b0, 20, rc, d, e, pc);
        check("b2b_lat3_cycle", rc, 32'd9);
        check("b2b_lat3_data",  d,  32'h1234_5678);
        check("b2b_lat3_psel",  pc, 32'd3);
        idle_cycle(MAIN, r, e);
        check("b2b_after_rdy", {31'd0, r}, 32'd0);

        // ---------------- RATIO 1.0, lat=5 -> wait floored ----------------
        pulse_reset();
        do_xfer(UNITY, 5, 1'b0, 32'h0BAD_F00D, 1'b0, 20, rc, d, e, pc);
        check("r1_lat5_cycle", rc, 32'd6);
        check("r1_lat5_data",  d,  32'h0BAD_F00D);
        check("r1_lat5_psel",  pc, 32'd5);

        // ---------------- RATIO 3.0 write with error, lat=4 -> 12 ----------
        pulse_reset();
        in_pstrb = 4'h3;
        do_xfer(MAIN, 4, 1'b1, 32'h7777_0000, 1'b1, 30, rc, d, e, pc);
        check("wr_err_cycle", rc, 32'd12);
        check("wr_err_err",   {31'd0, e}, 32'd1);
        check("wr_err_psel",  pc, 32'd4);
        idle_cycle(MAIN, r, e);
        check("wr_err_after_rdy", {31'd0, r}, 32'd0);
        check("wr_err_after_err", {31'd0, e}, 32'd0);
        in_pstrb  = 4'hF;
        in_pwrite = 1'b0;

        // ---------------- abort during HOLD ------------------------------
        pulse_reset();
        seen = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            in_psel     = (cyc <= 3);
            in_penable  = (cyc == 2) || (cyc == 3);
            out_pready  = (cyc == 2);
            out_prdata  = (cyc == 2) ? 32'h3C3C_3C3C : 32'h0;
            out_pslverr = 1'b0;
            @(negedge clock);
            seen += int'(rdy[MAIN]);
            if (cyc == 3) check("abort_hold_gate", {31'd0, o_psel[MAIN]}, 32'd0);
            next_cycle();
        end
        check("abort_no_ready", seen, 32'd0);
        do_xfer(MAIN, 2, 1'b0, 32'h0000_ABCD, 1'b0, 20, rc, d, e, pc);
        check("post_abort_cycle", rc, 32'd6);
        check("post_abort_data",  d,  32'h0000_ABCD);
        idle_cycle(MAIN, r, e);

        // ---------------- reset pulse mid-HOLD ---------------------------
        pulse_reset();
        in_psel = 1'b1; in_penable = 1'b0;
        next_cycle();                                   // cycle 2
        in_penable = 1'b1; out_pready = 1'b1; out_prdata = 32'hCAFE_0001;
        next_cycle();                                   // cycle 3 (HOLD)
        out_pready = 1'b0; out_prdata = '0;
        next_cycle();                                   // cycle 4 (HOLD)
        reset = 1'b0;
        #1;
        check("rst_hold_pready", {31'd0, rdy[MAIN]},   32'd0);
        check("rst_hold_prdata", rdat[MAIN],           32'd0);
        check("rst_hold_psel",   {31'd0, o_psel[MAIN]}, 32'd0);
        check("rst_hold_pen",    {31'd0, o_pen[MAIN]},  32'd0);
        next_cycle();
        drive_idle();
        #1;
        reset = 1'b1;
        next_cycle();
        do_xfer(MAIN, 3, 1'b0, 32'h0101_0202, 1'b0, 20, rc, d, e, pc);
        check("post_rst_cycle", rc, 32'd9);
        check("post_rst_data",  d,  32'h0101_0202);
        idle_cycle(MAIN, r, e);

        // ---------------- reset asserted during RESP ---------------------
        pulse_reset();
        in_psel = 1'b1; in_penable = 1'b0;
        next_cycle();                                   // cycle 2
        in_penable = 1'b1; out_pready = 1'b1; out_prdata = 32'hA5A5_A5A5;
        next_cycle();                                   // cycle 3
        out_pready = 1'b0; out_prdata = '0;
        next_cycle();                                   // cycle 4
        next_cycle();                                   // cycle 5
        next_cycle();                                   // cycle 6 (RESP)
        #1;
        check("resp_pready", {31'd0, rdy[MAIN]}, 32'd1);
        check("resp_prdata", rdat[MAIN],         32'hA5A5_A5A5);
        reset = 1'b0;
        #1;
        check("resp_rst_pready", {31'd0, rdy[MAIN]}, 32'd0);
        check("resp_rst_prdata", rdat[MAIN],         32'd0);
        next_cycle();
        drive_idle();
        #1;
        reset = 1'b1;
        next_cycle();

        // ---------------- saturation: CNT_W=4, lat=20 --------------------
        pulse_reset();
        do_xfer(SAT, 20, 1'b0, 32'hFACE_0015, 1'b0, 60, rc, d, e, pc);
        check("sat_cycle", rc, 32'd36);
        check("sat_data",  d,  32'hFACE_0015);
        check("sat_psel",  pc, 32'd20);
        idle_cycle(SAT, r, e);
        check("sat_after_rdy", {31'd0, r}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
